// File: rtl/jtkonami_colmix_nlayer.sv
// N-layer colour mixer: per-pixel winner selection under a CPU-set priority mode,
// two-byte palette fetch from shared RAM, and a blanking-aligned RGB output line.
module jtkonami_colmix_nlayer #(
   parameter  int LAYERS    = 3,
   parameter  int PW        = 7,
   parameter  int BLANK_DLY = 3,
   localparam int LSEL      = $clog2(LAYERS),
   localparam int AW        = LSEL + PW + 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 pxl_cen,
   input  logic                 LHBL,
   input  logic                 LVBL,
   output logic                 LHBL_dly,
   output logic                 LVBL_dly,
   input  logic                 pal_cs,
   input  logic                 prio_cs,
   input  logic                 cpu_rnw,
   input  logic                 cpu_cen,
   input  logic [AW-1:0]        cpu_addr,
   input  logic [7:0]           cpu_dout,
   output logic [7:0]           pal_dout,
   input  logic [LAYERS*PW-1:0] gfx_pxl,
   output logic [4:0]           red,
   output logic [4:0]           green,
   output logic [4:0]           blue
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] LO   = 2'd1;
   localparam logic [1:0] HI   = 2'd2;
   localparam logic [1:0] ASM  = 2'd3;

   logic [7:0]      mem [0:2**AW-1];
   logic [7:0]      vid_q;
   logic [AW-1:0]   vid_addr;
   logic            pal_we;

   logic [PW-1:0]   layer_pxl [LAYERS];
   logic [LAYERS-1:0] nonblank;
   logic [LAYERS-1:0] flag;
   logic [LSEL-1:0] win;
   logic [AW-2:0]   win_addr;

   logic [1:0]      prio;
   logic [1:0]      state;
   logic [AW-2:0]   fetch_addr;
   logic [7:0]      lo_byte;
   logic [14:0]     col_reg;
   logic            lhbl_f;
   logic            lvbl_f;

   logic [14:0]     col_dly [BLANK_DLY-1];
   logic [BLANK_DLY-2:0] hb_dly;
   logic [BLANK_DLY-2:0] vb_dly;
   logic            visible;
   logic            unused_bit;

   genvar gi;
   generate
      for (gi = 0; gi < LAYERS; gi++) begin : g_layer
         assign layer_pxl[gi] = gfx_pxl[gi*PW +: PW];
         assign nonblank[gi]  = |gfx_pxl[gi*PW +: 4];
         assign flag[gi]      = gfx_pxl[gi*PW + 4];
      end
   endgenerate

   // Scanning order makes the last match win; all-blank leaves the top layer as backdrop.
   always_comb begin
      win = LSEL'(LAYERS - 1);
      case (prio)
         2'd1: begin
            for (int i = LAYERS - 1; i >= 0; i--)
               if (nonblank[i]) win = LSEL'(i);
            for (int i = LAYERS - 1; i >= 0; i--)
               if (nonblank[i] && flag[i]) win = LSEL'(i);
         end
         2'd2: begin
            for (int i = 0; i < LAYERS; i++)
               if (nonblank[i]) win = LSEL'(i);
         end
         default: begin
            for (int i = LAYERS - 1; i >= 0; i--)
               if (nonblank[i]) win = LSEL'(i);
         end
      endcase
   end

   assign win_addr = {win, layer_pxl[win]};
   assign vid_addr = {fetch_addr, state == HI};
   assign pal_we   = pal_cs & ~cpu_rnw & cpu_cen;

   // Read-before-write on both ports: a colliding video read sees the old byte.
   always_ff @(posedge clk) begin
      if (pal_we) mem[cpu_addr] <= cpu_dout;
      vid_q <= mem[vid_addr];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pal_dout <= 8'd0;
      else        pal_dout <= mem[cpu_addr];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                             prio <= 2'd0;
      else if (prio_cs & cpu_cen & ~cpu_rnw)  prio <= cpu_dout[1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         fetch_addr <= '0;
         lo_byte    <= 8'd0;
         col_reg    <= 15'd0;
         lhbl_f     <= 1'b0;
         lvbl_f     <= 1'b0;
      end else if (pxl_cen) begin
         state      <= LO;
         fetch_addr <= win_addr;
         lhbl_f     <= LHBL;
         lvbl_f     <= LVBL;
      end else begin
         case (state)
            LO:      state <= HI;
            HI: begin
               lo_byte <= vid_q;
               state   <= ASM;
            end
            ASM: begin
               col_reg <= {vid_q[6:0], lo_byte};
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int j = 0; j < BLANK_DLY - 1; j++) col_dly[j] <= 15'd0;
         hb_dly <= '0;
         vb_dly <= '0;
      end else if (pxl_cen) begin
         col_dly[0] <= col_reg;
         hb_dly[0]  <= lhbl_f;
         vb_dly[0]  <= lvbl_f;
         for (int j = 1; j < BLANK_DLY - 1; j++) begin
            col_dly[j] <= col_dly[j-1];
            hb_dly[j]  <= hb_dly[j-1];
            vb_dly[j]  <= vb_dly[j-1];
         end
      end
   end

   assign LHBL_dly = hb_dly[BLANK_DLY-2];
   assign LVBL_dly = vb_dly[BLANK_DLY-2];
   assign visible  = LHBL_dly & LVBL_dly;
   assign {blue, green, red} = visible ? col_dly[BLANK_DLY-2] : 15'd0;

   assign unused_bit = vid_q[7];

endmodule
